// File: rtl/fp_mult_pkg.sv
// fp_mult_pkg: shared widths, stage-1 register layout and status flag
// types for the floating-point multiplier normalise/round back end.
package fp_mult_pkg;

   localparam int FP_SIG_WIDTH = 23;
   localparam int FP_EX_WIDTH  = 8;
   localparam int MAXE         = (1 << FP_EX_WIDTH) - 1;

   // Normalised product held between the normalise and round stages.
   // exp keeps two extra bits so increments and negative values never wrap.
   typedef struct packed {
      logic                      sign;
      logic [FP_SIG_WIDTH-1:0]   frac;
      logic                      guard;
      logic                      sticky;
      logic [FP_EX_WIDTH+1:0]    exp;
      logic                      zero;
   } s1_reg_t;

   typedef struct packed {
      logic overflow;
      logic underflow;
      logic inexact;
   } fp_flags_t;

endpackage

// File: rtl/fp_mult_round_rne.sv
// fp_mult_round_rne: combinational round, carry handling and packing.
// With FP_MULT_RNE_EN defined it rounds to nearest, ties to even; without
// it the fraction is truncated and guard/sticky only feed the inexact flag.
module fp_mult_round_rne
   import fp_mult_pkg::*;
#(
   parameter int SIG_WIDTH = FP_SIG_WIDTH,
   parameter int EX_WIDTH  = FP_EX_WIDTH
) (
   input  s1_reg_t                        s1,
   output logic [EX_WIDTH+SIG_WIDTH:0]    result,
   output fp_flags_t                      flags
);

   localparam logic signed [EX_WIDTH+1:0] MAXE_S = (EX_WIDTH+2)'(MAXE);
   localparam logic signed [EX_WIDTH+1:0] ZERO_S = '0;

   logic [SIG_WIDTH-1:0]        frac_r;
   logic signed [EX_WIDTH+1:0]  exp_f;

`ifdef FP_MULT_RNE_EN
   logic               round_up;
   logic [SIG_WIDTH:0] frac_sum;

   // Round to nearest even; a carry out of the fraction wraps it to zero
   // and bumps the exponent.
   always_comb begin
      round_up = s1.guard & (s1.sticky | s1.frac[0]);
      frac_sum = {1'b0, s1.frac} + {{SIG_WIDTH{1'b0}}, round_up};
      frac_r   = frac_sum[SIG_WIDTH-1:0];
      exp_f    = s1.exp + {{(EX_WIDTH+1){1'b0}}, frac_sum[SIG_WIDTH]};
   end
`else
   assign frac_r = s1.frac;
   assign exp_f  = s1.exp;
`endif

   // Classify the final exponent and pack sign/exponent/fraction.
   always_comb begin
      result = '0;
      flags  = '0;
      if (s1.zero) begin
         result = {s1.sign, {EX_WIDTH{1'b0}}, {SIG_WIDTH{1'b0}}};
      end else if (exp_f >= MAXE_S) begin
         result          = {s1.sign, {EX_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
         flags.overflow  = 1'b1;
         flags.inexact   = 1'b1;
      end else if (exp_f <= ZERO_S) begin
         // Subnormal range is flushed to a signed zero.
         result          = {s1.sign, {EX_WIDTH{1'b0}}, {SIG_WIDTH{1'b0}}};
         flags.underflow = 1'b1;
         flags.inexact   = 1'b1;
      end else begin
         result          = {s1.sign, exp_f[EX_WIDTH-1:0], frac_r};
         flags.inexact   = s1.guard | s1.sticky;
      end
   end

endmodule

// File: rtl/fp_mult_norm_round_pipe.sv
// fp_mult_norm_round_pipe: two-stage stallable normalise-and-round back end
// for the FP multiplier. Stage 1 normalises the raw significand product,
// stage 2 rounds and packs. Optional round-to-nearest-even is enabled by
// defining FP_MULT_RNE_EN (default build truncates).
module fp_mult_norm_round_pipe
   import fp_mult_pkg::*;
#(
   parameter int SIG_WIDTH = FP_SIG_WIDTH,
   parameter int EX_WIDTH  = FP_EX_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          in_sign,
   input  logic [2*SIG_WIDTH+1:0]        in_mant_mult,
   input  logic [EX_WIDTH+1:0]           in_exp_sub,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [EX_WIDTH+SIG_WIDTH:0]   out_result,
   output logic                          out_overflow,
   output logic                          out_underflow,
   output logic                          out_inexact
);

   s1_reg_t                        s1_reg;
   s1_reg_t                        s1_next;
   logic                           v1_reg;
   logic                           v2_reg;
   logic [EX_WIDTH+SIG_WIDTH:0]    out_result_reg;
   fp_flags_t                      flags_reg;
   logic [EX_WIDTH+SIG_WIDTH:0]    rnd_result;
   fp_flags_t                      rnd_flags;
   logic                           adv1;
   logic                           adv2;

   // A stage may load when it is empty or the stage after it is draining.
   assign adv2     = !v2_reg | out_ready;
   assign adv1     = !v1_reg | adv2;
   assign in_ready = adv1;

   // Normalise: a product >= 2.0 shifts right one place and bumps exp.
   always_comb begin
      s1_next      = '0;
      s1_next.sign = in_sign;
      s1_next.zero = (in_mant_mult == '0);
      if (in_mant_mult[2*SIG_WIDTH+1]) begin
         s1_next.frac   = in_mant_mult[2*SIG_WIDTH:SIG_WIDTH+1];
         s1_next.guard  = in_mant_mult[SIG_WIDTH];
         s1_next.sticky = |in_mant_mult[SIG_WIDTH-1:0];
         s1_next.exp    = in_exp_sub + (EX_WIDTH+2)'(1);
      end else begin
         s1_next.frac   = in_mant_mult[2*SIG_WIDTH-1:SIG_WIDTH];
         s1_next.guard  = in_mant_mult[SIG_WIDTH-1];
         s1_next.sticky = |in_mant_mult[SIG_WIDTH-2:0];
         s1_next.exp    = in_exp_sub;
      end
   end

   // Stage 1 register: accept a beat whenever the stage can advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_reg <= 1'b0;
         s1_reg <= '0;
      end else if (adv1) begin
         v1_reg <= in_valid;
         if (in_valid) begin
            s1_reg <= s1_next;
         end
      end
   end

   fp_mult_round_rne #(
      .SIG_WIDTH (SIG_WIDTH),
      .EX_WIDTH  (EX_WIDTH)
   ) u_round (
      .s1     (s1_reg),
      .result (rnd_result),
      .flags  (rnd_flags)
   );

   // Stage 2 register: outputs only change on a real beat, so a stalled
   // result stays stable and bubbles leave the last value untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         v2_reg         <= 1'b0;
         out_result_reg <= '0;
         flags_reg      <= '0;
      end else if (adv2) begin
         v2_reg <= v1_reg;
         if (v1_reg) begin
            out_result_reg <= rnd_result;
            flags_reg      <= rnd_flags;
         end
      end
   end

   assign out_valid     = v2_reg;
   assign out_result    = out_result_reg;
   assign out_overflow  = flags_reg.overflow;
   assign out_underflow = flags_reg.underflow;
   assign out_inexact   = flags_reg.inexact;

endmodule

// File: tb/tb_fp_mult_norm_round_pipe.sv
// tb_fp_mult_norm_round_pipe: directed-vector bench for the normalise/round
// pipeline; expectations follow the build's FP_MULT_RNE_EN setting.
module tb_fp_mult_norm_round_pipe;

   localparam int NV = 12;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [47:0] in_mant_mult;
   logic [9:0]  in_exp_sub;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_overflow;
   logic        out_underflow;
   logic        out_inexact;

   int n_checks = 0;
   int n_fail   = 0;

   logic        v_sign [NV];
   logic [47:0] v_mant [NV];
   logic [9:0]  v_exp  [NV];
   logic [31:0] e_res  [NV];
   logic [2:0]  e_flg  [NV];

   fp_mult_norm_round_pipe dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_sign       (in_sign),
      .in_mant_mult  (in_mant_mult),
      .in_exp_sub    (in_exp_sub),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_result    (out_result),
      .out_overflow  (out_overflow),
      .out_underflow (out_underflow),
      .out_inexact   (out_inexact)
   );

   always #5 clk = ~clk;

   // Product with bit 47 set: {1, frac[22:0], guard, sticky bits[22:0]}.
   function automatic logic [47:0] mk_hi(input logic [22:0] frac, input logic g,
                                         input logic [22:0] st);
      return {1'b1, frac, g, st};
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i);
      in_sign      = v_sign[i];
      in_mant_mult = v_mant[i];
      in_exp_sub   = v_exp[i];
   endtask

   // Expected values worked out by hand; flags are {overflow, underflow, inexact}.
   task automatic init_vectors;
      // 1.5 x 1.5 = 2.25
      v_sign[0] = 1'b0; v_mant[0] = 48'h9000_0000_0000; v_exp[0] = 10'd127;
      e_res[0] = 32'h4010_0000; e_flg[0] = 3'b000;
      // tie, even LSB
      v_sign[1] = 1'b0; v_mant[1] = mk_hi(23'h000002, 1'b1, 23'h0); v_exp[1] = 10'd127;
      e_res[1] = 32'h4000_0002; e_flg[1] = 3'b001;
      // tie, odd LSB
      v_sign[2] = 1'b0; v_mant[2] = mk_hi(23'h000003, 1'b1, 23'h0); v_exp[2] = 10'd127;
      // tie, all-ones fraction
      v_sign[3] = 1'b0; v_mant[3] = mk_hi(23'h7FFFFF, 1'b1, 23'h0); v_exp[3] = 10'd127;
      // above half
      v_sign[4] = 1'b0; v_mant[4] = mk_hi(23'h000002, 1'b1, 23'h000100); v_exp[4] = 10'd127;
      // overflow
      v_sign[5] = 1'b0; v_mant[5] = mk_hi(23'h0, 1'b0, 23'h0); v_exp[5] = 10'd254;
      e_res[5] = 32'h7F80_0000; e_flg[5] = 3'b101;
      // underflow, exp exactly 0
      v_sign[6] = 1'b0; v_mant[6] = 48'h4000_0000_0000; v_exp[6] = 10'd0;
      e_res[6] = 32'h0000_0000; e_flg[6] = 3'b011;
      // zero product, negative sign
      v_sign[7] = 1'b1; v_mant[7] = 48'h0; v_exp[7] = 10'd127;
      e_res[7] = 32'h8000_0000; e_flg[7] = 3'b000;
      // MSB clear, exact
      v_sign[8] = 1'b1; v_mant[8] = {2'b01, 23'h123456, 1'b0, 22'h0}; v_exp[8] = 10'd127;
      e_res[8] = 32'hBF92_3456; e_flg[8] = 3'b000;
      // negative exponent (-5)
      v_sign[9] = 1'b1; v_mant[9] = mk_hi(23'h0, 1'b0, 23'h0); v_exp[9] = 10'h3FB;
      e_res[9] = 32'h8000_0000; e_flg[9] = 3'b011;
      // sticky only
      v_sign[10] = 1'b0; v_mant[10] = mk_hi(23'h000001, 1'b0, 23'h000001); v_exp[10] = 10'd127;
      e_res[10] = 32'h4000_0001; e_flg[10] = 3'b001;
      // largest finite with tie
      v_sign[11] = 1'b0; v_mant[11] = mk_hi(23'h7FFFFF, 1'b1, 23'h0); v_exp[11] = 10'd253;
`ifdef FP_MULT_RNE_EN
      e_res[2]  = 32'h4000_0004; e_flg[2]  = 3'b001;
      e_res[3]  = 32'h4080_0000; e_flg[3]  = 3'b001;
      e_res[4]  = 32'h4000_0003; e_flg[4]  = 3'b001;
      e_res[11] = 32'h7F80_0000; e_flg[11] = 3'b101;
`else
      e_res[2]  = 32'h4000_0003; e_flg[2]  = 3'b001;
      e_res[3]  = 32'h407F_FFFF; e_flg[3]  = 3'b001;
      e_res[4]  = 32'h4000_0002; e_flg[4]  = 3'b001;
      e_res[11] = 32'h7F7F_FFFF; e_flg[11] = 3'b001;
`endif
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_sign = 1'b0; in_mant_mult = '0; in_exp_sub = '0;
      step; step;
      n_checks++;
      if ({out_valid, in_ready, out_result, out_overflow, out_underflow, out_inexact}
          !== {1'b0, 1'b1, 32'h0, 3'b000}) begin
         n_fail++;
         $display("FAIL reset: valid=%b ready=%b result=%h flags=%b, want 0 1 00000000 000",
                  out_valid, in_ready, out_result, {out_overflow, out_underflow, out_inexact});
      end
      rst = 1'b0;
      step;
   endtask

   task automatic test_single;
      out_ready = 1'b1;
      for (int i = 0; i < NV; i++) begin
         drive(i);
         in_valid = 1'b1;
         #1;
         n_checks++;
         if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single[%0d] in_ready: got %b want 1", i, in_ready);
         end
         step;
         in_valid = 1'b0;
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single[%0d] latency1: out_valid got %b want 0", i, out_valid);
         end
         step;
         n_checks++;
         if ({out_valid, out_result, out_overflow, out_underflow, out_inexact}
             !== {1'b1, e_res[i], e_flg[i]}) begin
            n_fail++;
            $display("FAIL single[%0d] result: valid=%b result=%h flags=%b, want 1 %h %b",
                     i, out_valid, out_result, {out_overflow, out_underflow, out_inexact},
                     e_res[i], e_flg[i]);
         end
         step;
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single[%0d] drain: out_valid got %b want 0", i, out_valid);
         end
      end
   endtask

   task automatic test_back_to_back;
      int  idx_in, idx_out, cyc;
      logic fire_in;
      idx_in = 0; idx_out = 0; cyc = 0; out_ready = 1'b1;
      while (idx_out < NV && cyc < 100) begin
         if (idx_in < NV) begin
            drive(idx_in);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (out_valid && out_ready) begin
            n_checks++;
            if ({out_result, out_overflow, out_underflow, out_inexact}
                !== {e_res[idx_out], e_flg[idx_out]}) begin
               n_fail++;
               $display("FAIL b2b[%0d]: result=%h flags=%b, want %h %b", idx_out, out_result,
                        {out_overflow, out_underflow, out_inexact}, e_res[idx_out], e_flg[idx_out]);
            end
            idx_out++;
         end
         fire_in = in_valid && in_ready;
         step;
         if (fire_in) idx_in++;
         cyc++;
      end
      in_valid = 1'b0;
      n_checks++;
      if (idx_out != NV || cyc != NV + 2) begin
         n_fail++;
         $display("FAIL b2b throughput: %0d results in %0d cycles, want %0d in %0d",
                  idx_out, cyc, NV, NV + 2);
      end
   endtask

   task automatic test_backpressure;
      int          bp_idx [4];
      int          idx_in, idx_out, cyc, k;
      logic        fire_in, held_valid;
      logic [34:0] held;
      bp_idx[0] = 2; bp_idx[1] = 3; bp_idx[2] = 5; bp_idx[3] = 6;
      idx_in = 0; idx_out = 0; cyc = 0; held_valid = 1'b0; held = '0;
      while (idx_out < 4 && cyc < 40) begin
         out_ready = (cyc >= 5);
         if (idx_in < 4) begin
            drive(bp_idx[idx_in]);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (held_valid) begin
            n_checks++;
            if ({out_valid, out_result, out_overflow, out_underflow, out_inexact} !== {1'b1, held}) begin
               n_fail++;
               $display("FAIL stall hold cyc%0d: valid=%b out=%h, want 1 %h", cyc, out_valid,
                        {out_result, out_overflow, out_underflow, out_inexact}, held);
            end
         end
         if (idx_in == 2 && !out_ready) begin
            n_checks++;
            if (in_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL stall in_ready cyc%0d: got %b want 0", cyc, in_ready);
            end
         end
         if (out_valid && out_ready) begin
            k = bp_idx[idx_out];
            n_checks++;
            if ({out_result, out_overflow, out_underflow, out_inexact} !== {e_res[k], e_flg[k]}) begin
               n_fail++;
               $display("FAIL bp[%0d]: result=%h flags=%b, want %h %b", idx_out, out_result,
                        {out_overflow, out_underflow, out_inexact}, e_res[k], e_flg[k]);
            end
            idx_out++;
         end
         held_valid = out_valid && !out_ready;
         held       = {out_result, out_overflow, out_underflow, out_inexact};
         fire_in    = in_valid && in_ready;
         step;
         if (fire_in) idx_in++;
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      n_checks++;
      if (idx_out != 4 || cyc != 9) begin
         n_fail++;
         $display("FAIL bp count: %0d results in %0d cycles, want 4 in 9", idx_out, cyc);
      end
      step;
   endtask

   task automatic test_reset_midflight;
      out_ready = 1'b0;
      drive(1);
      in_valid = 1'b1;
      step; step;
      in_valid = 1'b0;
      n_checks++;
      if ({out_valid, in_ready} !== 2'b10) begin
         n_fail++;
         $display("FAIL midrst fill: valid=%b ready=%b, want 1 0", out_valid, in_ready);
      end
      rst = 1'b1;
      step;
      rst = 1'b0;
      n_checks++;
      if ({out_valid, in_ready, out_result, out_overflow, out_underflow, out_inexact}
          !== {1'b0, 1'b1, 32'h0, 3'b000}) begin
         n_fail++;
         $display("FAIL midrst clear: valid=%b ready=%b result=%h flags=%b, want 0 1 00000000 000",
                  out_valid, in_ready, out_result, {out_overflow, out_underflow, out_inexact});
      end
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step;
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst ghost cyc%0d: out_valid got %b want 0", c, out_valid);
         end
      end
      drive(8);
      in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      step;
      n_checks++;
      if ({out_valid, out_result, out_overflow, out_underflow, out_inexact}
          !== {1'b1, e_res[8], e_flg[8]}) begin
         n_fail++;
         $display("FAIL midrst after: valid=%b result=%h flags=%b, want 1 %h %b", out_valid,
                  out_result, {out_overflow, out_underflow, out_inexact}, e_res[8], e_flg[8]);
      end
      step;
   endtask

   initial begin
      init_vectors;
      test_reset;
      test_single;
      test_back_to_back;
      test_backpressure;
      test_reset_midflight;
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
